// File: rtl/sequenciador_movimento_pkg.sv
// Shared types for the freeway player sequencer: FSM states, direction
// indices, and the facing codes that the renderer also decodes.
package sequenciador_movimento_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_COOL,
        ST_WIN,
        ST_HIT
    } estado_t;

    typedef enum logic [1:0] {
        DIR_CIMA     = 2'd0,
        DIR_BAIXO    = 2'd1,
        DIR_ESQUERDA = 2'd2,
        DIR_DIREITA  = 2'd3
    } direcao_t;

    localparam logic [3:0] COD_DIREITA  = 4'b0011;
    localparam logic [3:0] COD_BAIXO    = 4'b1100;
    localparam logic [3:0] COD_ESQUERDA = 4'b0001;
    localparam logic [3:0] COD_CIMA     = 4'b0100;

    localparam int PONTOS_W = 8;
    localparam int CNT_W    = 8;

    function automatic logic [3:0] codigoDir(input direcao_t d);
        case (d)
            DIR_CIMA:     return COD_CIMA;
            DIR_BAIXO:    return COD_BAIXO;
            DIR_ESQUERDA: return COD_ESQUERDA;
            default:      return COD_DIREITA;
        endcase
    endfunction

endpackage

// File: rtl/sequenciador_movimento_detector_borda.sv
// Rising-edge detector for the four direction buttons with a fixed
// priority encoder (cima > baixo > esquerda > direita).
module detector_borda
    import sequenciador_movimento_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] botoes_i,
    output logic       valido_o,
    output direcao_t   direcao_o
);

    logic [3:0] hist_q;
    logic [3:0] bordas;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) hist_q <= 4'b0000;
        else       hist_q <= botoes_i;
    end

    // History is updated every clk, so a held button never re-triggers.
    always_comb begin
        bordas    = botoes_i & ~hist_q;
        valido_o  = |bordas;
        direcao_o = DIR_DIREITA;
        if (bordas[3])      direcao_o = DIR_CIMA;
        else if (bordas[2]) direcao_o = DIR_BAIXO;
        else if (bordas[1]) direcao_o = DIR_ESQUERDA;
    end

endmodule

// File: rtl/sequenciador_movimento.sv
// Player-movement sequencer: one grid step per tick after a button press,
// with cooldown, playfield clamping, collision freeze and goal scoring.
module sequenciador_movimento
    import sequenciador_movimento_pkg::*;
#(
    parameter int COLS       = 16,
    parameter int ROWS       = 12,
    parameter int START_X    = 8,
    parameter int COOL_TICKS = 2,
    parameter int HIT_TICKS  = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick,
    input  logic                cima,
    input  logic                baixo,
    input  logic                esquerda,
    input  logic                direita,
    input  logic                colisao,
    output logic [3:0]          pos_x,
    output logic [3:0]          pos_y,
    output logic [3:0]          dir,
    output logic                moving,
    output logic                morto,
    output logic                vitoria,
    output logic [PONTOS_W-1:0] pontos
);

    localparam logic [3:0]       X_MAX    = 4'(COLS - 1);
    localparam logic [3:0]       Y_MAX    = 4'(ROWS - 1);
    localparam logic [3:0]       X_INI    = 4'(START_X);
    localparam logic [CNT_W-1:0] CNT_COOL = CNT_W'(COOL_TICKS);
    localparam logic [CNT_W-1:0] CNT_HIT  = CNT_W'(HIT_TICKS);

    estado_t             estado_q;
    direcao_t            pend_q;
    logic [3:0]          pos_x_q, pos_y_q, dir_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [PONTOS_W-1:0] pontos_q;
    logic                moving_q, morto_q, vitoria_q;

    logic                req_valido;
    direcao_t            req_dir;
    logic [3:0]          pos_x_d, pos_y_d;

    detector_borda u_detector (
        .clk      (clk),
        .reset    (reset),
        .botoes_i ({cima, baixo, esquerda, direita}),
        .valido_o (req_valido),
        .direcao_o(req_dir)
    );

    // Candidate position for the pending step; a step off the edge is a no-op.
    always_comb begin
        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;
        case (pend_q)
            DIR_CIMA:     if (pos_y_q != 4'd0)  pos_y_d = pos_y_q - 4'd1;
            DIR_BAIXO:    if (pos_y_q != Y_MAX) pos_y_d = pos_y_q + 4'd1;
            DIR_ESQUERDA: if (pos_x_q != 4'd0)  pos_x_d = pos_x_q - 4'd1;
            default:      if (pos_x_q != X_MAX) pos_x_d = pos_x_q + 4'd1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q  <= ST_IDLE;
            pend_q    <= DIR_DIREITA;
            pos_x_q   <= X_INI;
            pos_y_q   <= Y_MAX;
            dir_q     <= COD_DIREITA;
            cnt_q     <= '0;
            pontos_q  <= '0;
            moving_q  <= 1'b0;
            morto_q   <= 1'b0;
            vitoria_q <= 1'b0;
        end else begin
            vitoria_q <= 1'b0;
            case (estado_q)
                ST_IDLE, ST_ARMED, ST_COOL: begin
                    if (colisao) begin
                        estado_q <= ST_HIT;
                        cnt_q    <= CNT_HIT;
                        morto_q  <= 1'b1;
                        moving_q <= 1'b0;
                    end else if (estado_q == ST_IDLE) begin
                        if (req_valido) begin
                            estado_q <= ST_ARMED;
                            pend_q   <= req_dir;
                            dir_q    <= codigoDir(req_dir);
                        end
                    end else if (estado_q == ST_ARMED) begin
                        if (tick) begin
                            pos_x_q <= pos_x_d;
                            pos_y_q <= pos_y_d;
                            if (pos_y_d == 4'd0) begin
                                estado_q  <= ST_WIN;
                                vitoria_q <= 1'b1;
                                if (pontos_q != '1) pontos_q <= pontos_q + PONTOS_W'(1);
                            end else if (COOL_TICKS == 0) begin
                                estado_q <= ST_IDLE;
                            end else begin
                                estado_q <= ST_COOL;
                                cnt_q    <= CNT_COOL;
                                moving_q <= 1'b1;
                            end
                        end
                    end else if (tick) begin
                        if (cnt_q <= CNT_W'(1)) begin
                            estado_q <= ST_IDLE;
                            cnt_q    <= '0;
                            moving_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                end
                ST_WIN: begin
                    estado_q <= ST_IDLE;
                    pos_x_q  <= X_INI;
                    pos_y_q  <= Y_MAX;
                    dir_q    <= COD_DIREITA;
                end
                ST_HIT: begin
                    if (tick) begin
                        if (cnt_q <= CNT_W'(1)) begin
                            estado_q <= ST_IDLE;
                            cnt_q    <= '0;
                            morto_q  <= 1'b0;
                            pos_x_q  <= X_INI;
                            pos_y_q  <= Y_MAX;
                            dir_q    <= COD_DIREITA;
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                end
                default: estado_q <= ST_IDLE;
            endcase
        end
    end

    assign pos_x   = pos_x_q;
    assign pos_y   = pos_y_q;
    assign dir     = dir_q;
    assign moving  = moving_q;
    assign morto   = morto_q;
    assign vitoria = vitoria_q;
    assign pontos  = pontos_q;

endmodule

// File: tb/tb_sequenciador_movimento.sv
// Directed self-checking bench for the freeway movement sequencer.
module tb_sequenciador_movimento;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       cima = 1'b0, baixo = 1'b0, esquerda = 1'b0, direita = 1'b0;
    logic       colisao = 1'b0;
    logic [3:0] pos_x, pos_y, dir;
    logic       moving, morto, vitoria;
    logic [7:0] pontos;

    int nComparacoes = 0;
    int nFalhas = 0;

    localparam logic [3:0] C_DIREITA  = 4'b0011;
    localparam logic [3:0] C_BAIXO    = 4'b1100;
    localparam logic [3:0] C_ESQUERDA = 4'b0001;
    localparam logic [3:0] C_CIMA     = 4'b0100;

    sequenciador_movimento dut (
        .clk     (clk),
        .reset   (reset),
        .tick    (tick),
        .cima    (cima),
        .baixo   (baixo),
        .esquerda(esquerda),
        .direita (direita),
        .colisao (colisao),
        .pos_x   (pos_x),
        .pos_y   (pos_y),
        .dir     (dir),
        .moving  (moving),
        .morto   (morto),
        .vitoria (vitoria),
        .pontos  (pontos)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        nComparacoes++;
        if (obs !== esp) begin
            nFalhas++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, esp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic ciclo();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Press {cima,baixo,esquerda,direita} for one clk, then release for one clk.
    task automatic applyStimulus(input logic [3:0] b);
        {cima, baixo, esquerda, direita} = b;
        ciclo();
        {cima, baixo, esquerda, direita} = 4'b0000;
        ciclo();
    endtask

    task automatic pulseTick();
        tick = 1'b1;
        ciclo();
        tick = 1'b0;
    endtask

    task automatic passo(input logic [3:0] b);
        applyStimulus(b);
        pulseTick();
        pulseTick();
        pulseTick();
    endtask

    // Eleven up-steps from row 11; returns with the player in WIN.
    task automatic subirAteTopo();
        for (int i = 0; i < 11; i++) begin
            applyStimulus(4'b1000);
            pulseTick();
            if (i < 10) begin
                pulseTick();
                pulseTick();
            end
        end
    endtask

    initial begin
        ciclo();
        checkOutput("reset_pos_x", pos_x, 8);
        checkOutput("reset_pos_y", pos_y, 11);
        checkOutput("reset_dir", dir, C_DIREITA);
        checkOutput("reset_flags", {moving, morto, vitoria}, 0);
        checkOutput("reset_pontos", pontos, 0);
        reset = 1'b0;
        ciclo();

        direita = 1'b1;
        ciclo();
        checkOutput("direita_dir", dir, C_DIREITA);
        direita = 1'b0;
        ciclo();
        checkOutput("armed_no_move", pos_x, 8);
        pulseTick();
        checkOutput("direita_pos_x", pos_x, 9);
        checkOutput("cool_moving1", moving, 1);
        pulseTick();
        checkOutput("cool_moving2", moving, 1);
        pulseTick();
        checkOutput("cool_done", moving, 0);

        esquerda = 1'b1;
        ciclo();
        checkOutput("esquerda_dir_1clk", dir, C_ESQUERDA);
        esquerda = 1'b0;
        ciclo();
        pulseTick();
        checkOutput("esquerda_pos_x", pos_x, 8);
        pulseTick();
        pulseTick();

        for (int i = 0; i < 7; i++) passo(4'b0001);
        checkOutput("reach_x15", pos_x, 15);
        applyStimulus(4'b0001);
        pulseTick();
        checkOutput("clamp_x15", pos_x, 15);
        checkOutput("clamp_moving", moving, 1);
        pulseTick();
        pulseTick();

        applyStimulus(4'b1010);
        checkOutput("prio_dir", dir, C_CIMA);
        pulseTick();
        checkOutput("prio_pos_y", pos_y, 10);
        checkOutput("prio_pos_x", pos_x, 15);
        pulseTick();
        pulseTick();

        applyStimulus(4'b0100);
        applyStimulus(4'b1000);
        checkOutput("first_wins_dir", dir, C_BAIXO);
        pulseTick();
        checkOutput("first_wins_pos_y", pos_y, 11);
        pulseTick();
        pulseTick();

        applyStimulus(4'b0010);
        colisao = 1'b1;
        tick = 1'b1;
        ciclo();
        colisao = 1'b0;
        tick = 1'b0;
        checkOutput("hit_morto", morto, 1);
        checkOutput("hit_no_step", pos_x, 15);
        applyStimulus(4'b1000);
        for (int i = 0; i < 7; i++) pulseTick();
        checkOutput("hit_still_morto", morto, 1);
        checkOutput("hit_frozen_y", pos_y, 11);
        pulseTick();
        checkOutput("respawn_morto", morto, 0);
        checkOutput("respawn_pos", {pos_x, pos_y}, {4'd8, 4'd11});
        checkOutput("respawn_dir", dir, C_DIREITA);
        pulseTick();
        checkOutput("hit_press_dropped", pos_y, 11);

        subirAteTopo();
        checkOutput("win_vitoria", vitoria, 1);
        checkOutput("win_pontos", pontos, 1);
        checkOutput("win_pos_y", pos_y, 0);
        ciclo();
        checkOutput("win_pulse_end", vitoria, 0);
        checkOutput("win_respawn", {pos_x, pos_y}, {4'd8, 4'd11});
        checkOutput("win_dir", dir, C_DIREITA);

        for (int w = 2; w <= 255; w++) begin
            subirAteTopo();
            ciclo();
        end
        checkOutput("pontos_255", pontos, 255);
        subirAteTopo();
        checkOutput("saturate_vitoria", vitoria, 1);
        checkOutput("pontos_saturated", pontos, 255);
        ciclo();

        colisao = 1'b1;
        ciclo();
        colisao = 1'b0;
        checkOutput("hit2_morto", morto, 1);
        #1 reset = 1'b1;
        #1;
        checkOutput("async_reset_morto", morto, 0);
        checkOutput("async_reset_pos", {pos_x, pos_y}, {4'd8, 4'd11});
        checkOutput("async_reset_dir", dir, C_DIREITA);
        checkOutput("async_reset_pontos", pontos, 0);
        checkOutput("async_reset_flags", {moving, vitoria}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nComparacoes, nFalhas);
        $finish;
    end

endmodule

// File: doc/sequenciador_movimento.md
Name: sequenciador_movimento

Overview:
Player-movement sequencer for the freeway game. Turns the four direction buttons into single grid steps, one per game tick, with a cooldown between steps. Clamps the player to the playfield, handles collision freeze/respawn and top-row scoring. Sits between the synchronized button inputs and the renderer/collision logic; drives player position, facing code and score.

Parameters:
COLS, 16, playfield width in cells (2..16); pos_x range 0..COLS-1
ROWS, 12, playfield height in cells (2..16); row 0 = goal, row ROWS-1 = start
START_X, 8, respawn column
COOL_TICKS, 2, ticks after a step before a new press is accepted (0 allowed)
HIT_TICKS, 8, ticks the player stays frozen after a collision (>=1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
tick  in  1  one-clk game-step strobe
cima  in  1  up button, synchronized level
baixo  in  1  down button, synchronized level
esquerda  in  1  left button, synchronized level
direita  in  1  right button, synchronized level
colisao  in  1  player overlaps a car (level, sampled every clk)
pos_x  out  4  player column
pos_y  out  4  player row
dir  out  4  facing code: right 0011, down 1100, left 0001, up 0100
moving  out  1  high while in COOL
morto  out  1  high while in HIT
vitoria  out  1  one-clk pulse when the goal row is reached
pontos  out  8  score, saturating

Behaviour:
- Reset (async): state IDLE, pos_x=START_X, pos_y=ROWS-1, dir=0011, pontos=0, all pulses/flags 0, button history cleared, counters 0.
- Edge detect: a request is the 0->1 edge of a button (history reg per button). Simultaneous edges resolve by priority cima > baixo > esquerda > direita.
- IDLE: on a request -> ARMED; latch the request as pending direction; dir updates to its code on the same edge.
- ARMED: further edges are ignored (first press wins).
  - On tick: apply the step. up y-1, down y+1, left x-1, right x+1.
  - Clamping: a step off the field (y=0 up, y=ROWS-1 down, x=0 left, x=COLS-1 right) leaves the position unchanged, but the step still counts and enters cooldown.
  - If the new y=0 -> WIN. Else if COOL_TICKS=0 -> IDLE. Else -> COOL with counter=COOL_TICKS.
- COOL: moving=1; counter decrements on tick; at 0 -> IDLE. Button edges are discarded (not queued).
- WIN (exactly one clk): vitoria=1; pontos+1, saturating at 255. Next clk: pos reset to START_X/ROWS-1, dir=0011, -> IDLE.
- Collision: colisao=1 in IDLE/ARMED/COOL -> HIT next clk. The pending step is dropped; morto=1; counter=HIT_TICKS.
  - colisao and tick in the same clk while ARMED: collision wins, no step taken.
  - colisao is ignored in WIN.
- HIT: position frozen; input edges discarded; counter decrements on tick. At 0: respawn (START_X, ROWS-1), dir=0011, morto=0 -> IDLE. colisao is ignored in HIT.
- A button held through COOL/HIT does not generate a new request; it must be released and pressed again.
- Latency: press -> dir change 1 clk; press -> position change on the first tick after ARMED is entered.
- All outputs registered. Async reset mid-operation returns to the reset state immediately, regardless of state.

Decomposition:
- Shared package: state encoding (IDLE, ARMED, COOL, WIN, HIT); the four dir codes (shared with the renderer); pontos width constant.
- One sub-module, detector_borda: 4-bit rising-edge detector plus priority encoder. Outputs a valid flag and a 2-bit direction.

Test Plan:
- Reset, press direita, one tick -> dir=0011, pos_x 8->9, moving=1 for 2 ticks, then IDLE.
- At pos_x=15 press direita, tick -> pos_x stays 15, moving=1 (cooldown still entered).
- cima and esquerda rise in the same clk -> dir=0100, pos_y decrements by 1, pos_x unchanged.
- Drive 11 presses of cima from row 11 -> on reaching row 0: vitoria pulses one clk, pontos=1, pos returns to (8,11).
- In ARMED assert colisao together with tick -> no step, morto=1 for 8 ticks, then respawn at (8,11) with dir=0011.
- Force pontos=255 and score again -> pontos stays 255; assert reset during HIT -> all outputs at reset values immediately.
